// File: rtl/nano_pkg.sv
// nano_pkg: shared register map for the nano GPIO input peripheral.
package nano_pkg;

  // Register select decoded from the 2-bit bus address.
  typedef enum logic [1:0] {
    GPIO_ADDR_LEVEL = 2'd0,
    GPIO_ADDR_RISE  = 2'd1,
    GPIO_ADDR_FALL  = 2'd2,
    GPIO_ADDR_MASK  = 2'd3
  } GPIO_ADDR_T;

endpackage

// File: rtl/nano_debounce.sv
// nano_debounce: one-bit 2-flop synchroniser plus debounce counter.
// stable_o moves to the synchronised value only after it has differed from
// stable_o for DEBOUNCE_CYCLES+1 consecutive samples; rise_o/fall_o are
// combinational and high on exactly the edge where stable_o will change.
module nano_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic areset_n,
  input  logic pin_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Count while the synchronised input disagrees; accept at terminal count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == TERMINAL) begin
        accept   = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Edge pulses aligned with the accepting edge.
  always_comb begin
    stable_o = stable_q;
    rise_o   = accept & sync2_q;
    fall_o   = accept & ~sync2_q;
  end

endmodule

// File: rtl/nano_gpio_in.sv
// nano_gpio_in: debounced GPIO input port on the nano CPU I/O bus.
// Registers: LEVEL (ro), RISE/FALL (sticky, write-1-to-clear), MASK.
// Build option NANO_GPIO_IRQ_EN adds the MASK register and the irq output;
// without it addr 3 reads 0 and writes there are ignored.
module nano_gpio_in
  import nano_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             areset_n,
  input  logic [WIDTH-1:0] pins,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ack
`ifdef NANO_GPIO_IRQ_EN
  ,
  output logic             irq
`endif
);

  GPIO_ADDR_T       addr_t;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise_ev;
  logic [WIDTH-1:0] fall_ev;
  logic [WIDTH-1:0] level_next;
  logic [WIDTH-1:0] clr_rise;
  logic [WIDTH-1:0] clr_fall;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             ack_q;
  logic             ack_d;
`ifdef NANO_GPIO_IRQ_EN
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic             irq_q;
  logic             irq_d;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    nano_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock   (clock),
      .areset_n(areset_n),
      .pin_i   (pins[g]),
      .stable_o(stable[g]),
      .rise_o  (rise_ev[g]),
      .fall_o  (fall_ev[g])
    );
  end

  // Bus decode, flag update with set-over-clear priority, read mux.
  // Reads see the level/flags as of the sampling edge (including events
  // accepted on that edge) but never the effect of a same-cycle clear.
  always_comb begin
    addr_t     = GPIO_ADDR_T'(addr);
    wr         = sel & we;
    rd         = sel & ~we;
    clr_rise   = (wr && addr_t == GPIO_ADDR_RISE) ? wdata : '0;
    clr_fall   = (wr && addr_t == GPIO_ADDR_FALL) ? wdata : '0;
    rise_d     = (rise_q & ~clr_rise) | rise_ev;
    fall_d     = (fall_q & ~clr_fall) | fall_ev;
    level_next = (stable & ~fall_ev) | rise_ev;
    rd_val     = '0;
    case (addr_t)
      GPIO_ADDR_LEVEL: rd_val = level_next;
      GPIO_ADDR_RISE:  rd_val = rise_q | rise_ev;
      GPIO_ADDR_FALL:  rd_val = fall_q | fall_ev;
`ifdef NANO_GPIO_IRQ_EN
      GPIO_ADDR_MASK:  rd_val = mask_q;
`else
      GPIO_ADDR_MASK:  rd_val = '0;
`endif
      default:         rd_val = '0;
    endcase
    rdata_d = rd ? rd_val : '0;
    ack_d   = sel;
  end

  // Sticky flags, read data and acknowledge registers.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      rise_q  <= '0;
      fall_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

`ifdef NANO_GPIO_IRQ_EN
  // Mask write and interrupt request from the current flags.
  always_comb begin
    mask_d = (wr && addr_t == GPIO_ADDR_MASK) ? wdata : mask_q;
    irq_d  = |((rise_q | fall_q) & mask_q);
  end

  // Mask and interrupt registers.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  assign rdata = rdata_q;
  assign ack   = ack_q;

endmodule

// File: doc/nano_gpio_in.md
# nano_gpio_in

Debounced general-purpose input port for the nano CPU: the input-direction counterpart of the `led` output on `nano_top`. It synchronises up to WIDTH asynchronous pins (buttons, switches) and debounces each one. It captures rising and falling edges as sticky event flags and presents level and events to the CPU through a single-cycle peripheral read/write strobe. It sits beside the LED output logic inside `nano_top` on the CPU I/O bus.

## Interface
- WIDTH, 4: number of input pins, 1..16.
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronised cycles required to accept a change (1 ms at 50 MHz); minimum 1.
- clock  in  1  system clock, rising edge.
- areset_n  in  1  asynchronous active-low reset; all state clears immediately on assertion and releases on the next clock edge after deassertion.
- pins  in  WIDTH  raw asynchronous input pins.
- sel  in  1  bus access strobe, one cycle per access.
- we  in  1  write when high with sel, read otherwise.
- addr  in  2  register select.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  registered read data, valid while ack=1, 0 otherwise.
- ack  out  1  access complete, pulses one cycle after sel.
- irq  out  1  interrupt request; present only with NANO_GPIO_IRQ_EN.

## Operation
- Registers:
  - addr 0 LEVEL: debounced level, read-only; writes are ignored.
  - addr 1 RISE: sticky rising-edge flags, write-1-to-clear.
  - addr 2 FALL: sticky falling-edge flags, write-1-to-clear.
  - addr 3 MASK: interrupt enable, R/W with NANO_GPIO_IRQ_EN, otherwise reads 0.
- Per pin, the input passes through a 2-flop synchroniser (sync1→sync2) and then a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
  - sync2 == stable: counter holds 0.
  - sync2 != stable: counter increments. When it reaches DEBOUNCE_CYCLES, stable takes sync2 and the counter returns to 0 on the same edge.
  - sync2 returns to stable before the terminal count: counter clears to 0 and nothing changes.
- Event flags:
  - RISE[i] sets on the edge where stable[i] goes 0→1.
  - FALL[i] sets on the edge where stable[i] goes 1→0.
- A W1C write with sel clears the flags whose wdata bit is 1. A set and a clear on the same edge: set wins, so the flag remains 1.
- Reset values: sync, stable, counters, RISE, FALL, MASK, rdata, ack and irq are all 0. A pin held high through reset therefore produces a RISE event DEBOUNCE_CYCLES+2 cycles after reset release; this is intended.
- Reset mid-debounce: the counter is lost and debouncing restarts from stable=0.

## Timing
- Pin change first sampled by sync1 at edge 0. With the pin held, stable and the event flag update at edge DEBOUNCE_CYCLES+2. LEVEL reads the new value from an access whose sel is sampled at that edge or later.
- Bus: sel sampled at edge n → ack=1 and rdata valid during cycle n+1. Writes take effect at edge n. sel may assert back-to-back; every sel gets exactly one ack.
- A read of RISE/FALL returns the value before any clear in the same cycle. Reads never clear flags.
- irq is registered: irq = |((RISE|FALL) & MASK), one cycle after the flag or mask changes.

## Configuration
- NANO_GPIO_IRQ_EN defined: MASK register and irq port exist.
- NANO_GPIO_IRQ_EN undefined: no irq port, no MASK flops, addr 3 reads 0, and writes to addr 3 are ignored (still acked).

## Structure
- Package nano_pkg holds the GPIO_ADDR_LEVEL/RISE/FALL/MASK constants (2-bit) and the GPIO_ADDR_T typedef.
- Sub-module nano_debounce is one-bit: synchroniser, counter, stable output, and rise/fall pulses. It has parameter DEBOUNCE_CYCLES and is instantiated WIDTH times via generate.
- The top level holds the flags, MASK, read mux and ack.

## Test plan
Bench runs with DEBOUNCE_CYCLES=4 and WIDTH=4.
- Reset with pins=0, then pins[0]=1 held → LEVEL=4'b0001 and RISE=4'b0001 at edge 6 after first sampling, not at edge 5.
- pins[1] pulses high for 3 cycles, then low → LEVEL and RISE stay 0; the counter clears.
- With RISE=4'b0001, write addr 1 wdata=4'b0001 → next read returns 0. Repeat the write on the exact edge a new pins[0] rise is accepted → RISE stays 4'b0001.
- Two back-to-back reads, addr 0 then addr 2 → ack high for two consecutive cycles with the correct rdata each, then ack=0 and rdata=0.
- Assert areset_n=0 mid-debounce (counter=2) → all outputs 0 immediately. After release, a held pin is accepted only after a full 4+2 cycles.
- With NANO_GPIO_IRQ_EN, MASK=4'b0100 and a pins[2] fall event → irq=1 one cycle after FALL[2] sets. Clearing FALL[2] → irq=0 one cycle later. A pins[3] event with MASK=4'b0100 leaves irq at 0.
